// File: rtl/vram_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between a ROM download byte stream (buffered in a small FIFO)
// and the vector RAM, with downloads always taking priority and repeated vector accesses suppressed.
module vram_port_arbiter #(
  parameter int unsigned DL_DEPTH = 4,
  parameter int unsigned VRAM_AW  = 11
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               dl_active,
  input  logic               dl_wr,
  input  logic [24:0]        dl_addr,
  input  logic [7:0]         dl_data,
  output logic               dl_overflow,
  input  logic [VRAM_AW-1:0] vram_addr,
  input  logic [15:0]        vram_din,
  input  logic               vram_we,
  input  logic               vram_cs1,
  input  logic               vram_cs2,
  output logic [15:0]        vram_dout,
  output logic               vram_busy,
  output logic               port_req,
  input  logic               port_ack,
  output logic [22:0]        port_a,
  output logic [1:0]         port_ds,
  output logic               port_we,
  output logic [15:0]        port_d,
  input  logic [15:0]        port_q
);

  localparam int unsigned PW = $clog2(DL_DEPTH);
  typedef logic [PW:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  typedef enum logic [1:0] {IDLE, WAIT_DL, WAIT_VR} state_t;

  state_t               state_q, state_d;
  logic                 dl_wr_q;
  ptr_t                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]          fifo_q [DL_DEPTH];
  logic                 ovf_q, ovf_d;
  logic                 req_q, req_d;
  logic [22:0]          a_q, a_d;
  logic [1:0]           ds_q, ds_d;
  logic                 we_q, we_d;
  logic [15:0]          d_q, d_d;
  logic [15:0]          dout_q, dout_d;
  logic [VRAM_AW-1:0]   last_addr_q, last_addr_d;
  logic                 last_we_q, last_we_d;

  logic                 fifo_empty, fifo_full, dl_rise, push, pop, hs, vr_new;
  logic [31:0]          head;
  logic                 unused_dl_addr_msb;

  assign unused_dl_addr_msb = dl_addr[24];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head       = fifo_q[rd_ptr_q[PW-1:0]];
  assign dl_rise    = dl_active & dl_wr & ~dl_wr_q;
  assign push       = dl_rise & (~fifo_full | pop);
  assign ovf_d      = ovf_q | (dl_rise & fifo_full & ~pop);
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign hs         = (port_ack == req_q);
  assign vr_new     = (vram_addr != last_addr_q) || (vram_we != last_we_q);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    req_d       = req_q;
    a_d         = a_q;
    ds_d        = ds_q;
    we_d        = we_q;
    d_d         = d_q;
    dout_d      = dout_q;
    last_addr_d = last_addr_q;
    last_we_d   = last_we_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            a_d     = head[31:9];
            ds_d    = {head[8], ~head[8]};
            we_d    = 1'b1;
            d_d     = {head[7:0], head[7:0]};
            req_d   = ~req_q;
            state_d = WAIT_DL;
          end else if (!dl_active && (vram_cs1 || vram_cs2) && vr_new) begin
            a_d         = 23'(vram_addr);
            ds_d        = {vram_cs2, vram_cs1};
            we_d        = vram_we;
            d_d         = vram_din;
            req_d       = ~req_q;
            last_addr_d = vram_addr;
            last_we_d   = vram_we;
            state_d     = WAIT_VR;
          end
        end
      end
      WAIT_DL: if (hs) state_d = IDLE;
      WAIT_VR: begin
        if (hs) begin
          state_d = IDLE;
          if (!we_q) dout_d = port_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= IDLE;
      dl_wr_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      req_q       <= 1'b0;
      a_q         <= '0;
      ds_q        <= '0;
      we_q        <= 1'b0;
      d_q         <= '0;
      dout_q      <= '0;
      last_addr_q <= '0;
      last_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_wr_q     <= dl_wr;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      req_q       <= req_d;
      a_q         <= a_d;
      ds_q        <= ds_d;
      we_q        <= we_d;
      d_q         <= d_d;
      dout_q      <= dout_d;
      last_addr_q <= last_addr_d;
      last_we_q   <= last_we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= {dl_addr[23:0], dl_data};
  end

  assign dl_overflow = ovf_q;
  assign vram_dout   = dout_q;
  assign vram_busy   = (state_q == WAIT_VR);
  assign port_req    = req_q;
  assign port_a      = a_q;
  assign port_ds     = ds_q;
  assign port_we     = we_q;
  assign port_d      = d_q;

endmodule
